hex_scroll_feed: RTL and testbench
==================================

// Module: hex_scroll_feed
// PURPOSE
//  Upstream feeder for the raw 7-segment multiplexer. Accepts a hex value (e.g. a golden nonce)
//  over a valid/ready handshake, encodes each nibble to a raw segment pattern, and scrolls the
//  digits right-to-left across the display one digit per scroll tick. Its word output drives the
//  multiplexer's raw segment word input directly (active-high segments; the multiplexer applies any inversion).
// PARAMETERS
//  SEG_UNITS     4     display digits; word width = SEG_UNITS*8
//  DATA_NIBBLES  8     hex digits per value; data_in width = DATA_NIBBLES*4 (>=1)
//  TICK_DIV      24'd12_500_000  clk cycles per scroll step (>=2)
//  HOLD_TICKS    2     scroll ticks the final SEG_UNITS digits stay static (0 = no hold)
// PORTS
//  clk         in   1                 system clock
//  rst_n       in   1                 asynchronous active-low reset
//  data_in     in   DATA_NIBBLES*4    value to display, MSB nibble shown first
//  data_valid  in   1                 data_in valid
//  data_ready  out  1                 block idle, can accept
//  word        out  SEG_UNITS*8       raw segments; byte 0 = rightmost digit, bits {dp,g,f,e,d,c,b,a}
//  busy        out  1                 scroll in progress
// BEHAVIOUR
//  - Clock clk, reset rst_n: one clock; reset asynchronous, active-low. While rst_n=0: word=0,
//    state IDLE, prescaler=0, digit counter=0; data_ready=1, busy=0 (both decoded from state).
//  - data_ready = (state==IDLE); busy = ~data_ready. Accept when data_valid & data_ready at a rising
//    edge: latch data_in into shift reg, clear prescaler and digit counter, go SHIFT_IN. Valid
//    while busy is ignored; data_in is not sampled. Valid may drop before acceptance.
//  - Prescaler counts 0..TICK_DIV-1 and wraps; tick = (cnt==TICK_DIV-1). First shift occurs on the
//    edge exactly TICK_DIV cycles after acceptance, then every TICK_DIV cycles.
//  - On each tick in SHIFT_IN: word <= {word[SEG_UNITS*8-9:0], seg(next nibble)}, MSB nibble first;
//    after DATA_NIBBLES ticks go HOLD (or SHIFT_OUT if HOLD_TICKS==0).
//  - HOLD: word static for HOLD_TICKS ticks, then SHIFT_OUT.
//  - SHIFT_OUT: each tick shift left inserting 8'h00; after SEG_UNITS ticks word==0, go IDLE.
//    Transition to IDLE happens on that final tick edge; data_ready=1 from next cycle.
//  - Total busy time = (DATA_NIBBLES+HOLD_TICKS+SEG_UNITS)*TICK_DIV cycles.
//  - If DATA_NIBBLES < SEG_UNITS, leading digits remain blank (zeros shifted in at reset/prior out).
//  - Bits shifted past the top byte are discarded; dp bit is always 0.
//  - Encoding {dp..a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//  - Reset mid-operation: word clears immediately (asynchronously), latched data discarded, IDLE.
//  - States: IDLE, SHIFT_IN, HOLD, SHIFT_OUT; 2-bit encoding; illegal state -> IDLE.
// STRUCTURE
//  - Shared package seg7_pkg: state enum constants, 16-entry hex->segment table, SEG_BLANK=8'h00.
//  - One sub-module: seg7_tick_gen (prescaler; inputs clk, rst_n, clear; output 1-cycle tick).
//  - Counters sized with $clog2 of DATA_NIBBLES, HOLD_TICKS+1, SEG_UNITS+1, TICK_DIV.
// TESTING (SEG_UNITS=4, DATA_NIBBLES=8, TICK_DIV=4, HOLD_TICKS=2)
//  1 Reset: rst_n=0 -> word=32'h0, data_ready=1, busy=0; release -> unchanged until valid.
//  2 Accept 32'h1234ABCD at edge k -> k+4: word=32'h00000006; k+16: 32'h065B4F66; k+32: 32'h777C395E.
//  3 Continue 2 -> word holds 32'h777C395E to k+40; k+44: 32'h7C395E00; k+56: 32'h0, data_ready=1.
//  4 Drive valid with 32'hFFFFFFFF at k+10 (busy) -> ignored; scroll of 1234ABCD unchanged.
//  5 Assert rst_n=0 mid-cycle at k+20 -> word=0 before next edge, IDLE, ready=1; new value scrolls cleanly.
//  6 Hold data_valid high with 32'h00000000 across completion -> accepted on first IDLE cycle;
//    4 cycles later word=32'h0000003F.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg7_pkg
// Brief  : Shared definitions for the hex scroll feeder: FSM state encoding,
//          hex-to-segment lookup table and the blank segment pattern.
//          Segment bit order is {dp,g,f,e,d,c,b,a}, active-high.
// Rev    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT_IN  = 2'd1,
        ST_HOLD      = 2'd2,
        ST_SHIFT_OUT = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Entry n holds the pattern for hex digit n (entry 0 in the low byte).
    // Lower-case b and d keep them distinguishable from 8 and 0.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39,   // F E d C
        8'h7C, 8'h77, 8'h6F, 8'h7F,   // b A 9 8
        8'h07, 8'h7D, 8'h6D, 8'h66,   // 7 6 5 4
        8'h4F, 8'h5B, 8'h06, 8'h3F    // 3 2 1 0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : seg7_tick_gen
// Brief  : Free-running prescaler that counts 0..TICK_DIV-1 and wraps,
//          producing a one-cycle tick on the terminal count. A clear pulse
//          restarts the count at zero so the first tick lands exactly
//          TICK_DIV cycles after the clear edge.
// Ports  : clk   - system clock
//          rst_n - asynchronous active-low reset
//          clear - synchronous restart of the count
//          tick  - high for one cycle when count == TICK_DIV-1
// Rev    : 1.0  initial release
// ============================================================================
module seg7_tick_gen #(
    parameter logic [23:0] TICK_DIV = 24'd12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int          c_CNT_W = $clog2(TICK_DIV);
    localparam logic [23:0] c_LAST  = TICK_DIV - 24'd1;

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST[c_CNT_W-1:0]);
    assign tick   = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_feed.sv
`default_nettype none
// ============================================================================
// Module : hex_scroll_feed
// Brief  : Accepts a hex value over valid/ready, then scrolls its digits
//          right-to-left across a raw 7-segment word, one digit per scroll
//          tick: shift in every nibble (MSB first), hold the last digits for
//          HOLD_TICKS ticks, then shift blanks in until the word is empty.
// Ports  : clk        - system clock
//          rst_n      - asynchronous active-low reset
//          data_in    - value to display, MSB nibble shown first
//          data_valid - data_in valid
//          data_ready - idle, value can be accepted
//          word       - raw segments, byte 0 = rightmost digit {dp,g..a}
//          busy       - scroll in progress
// Rev    : 1.0  initial release
// ============================================================================
module hex_scroll_feed
    import seg7_pkg::*;
#(
    parameter int          SEG_UNITS    = 4,
    parameter int          DATA_NIBBLES = 8,
    parameter logic [23:0] TICK_DIV     = 24'd12_500_000,
    parameter int          HOLD_TICKS   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_NIBBLES*4-1:0] data_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic [SEG_UNITS*8-1:0]    word,
    output logic                      busy
);

    localparam int c_WORD_W = SEG_UNITS * 8;
    localparam int c_DATA_W = DATA_NIBBLES * 4;
    // Counter widths are floored at one bit so degenerate parameter values
    // (one nibble, no hold) still produce legal vectors.
    localparam int c_DIG_W  = (DATA_NIBBLES > 1) ? $clog2(DATA_NIBBLES) : 1;
    localparam int c_HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int c_OUT_W  = $clog2(SEG_UNITS + 1);

    localparam logic [c_DIG_W-1:0]  c_DIG_LAST  = c_DIG_W'(DATA_NIBBLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);
    localparam logic [c_OUT_W-1:0]  c_OUT_LAST  = c_OUT_W'(SEG_UNITS - 1);

    state_t                r_state;
    logic [c_DATA_W-1:0]   r_data;
    logic [c_WORD_W-1:0]   r_word;
    logic [c_DIG_W-1:0]    r_dig_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_OUT_W-1:0]    r_out_cnt;

    logic                  w_tick;
    logic                  w_accept;
    logic [7:0]            w_seg;
    logic [c_WORD_W-1:0]   w_word_in;
    logic [c_WORD_W-1:0]   w_word_out;

    assign data_ready = (r_state == ST_IDLE);
    assign busy       = ~data_ready;
    assign word       = r_word;
    assign w_accept   = data_valid && data_ready;

    // Next digit always comes from the top nibble; the data register shifts
    // left after each use. Bits leaving the top byte of the word are dropped.
    assign w_seg      = hex_to_seg(r_data[c_DATA_W-1 -: 4]);
    assign w_word_in  = (r_word << 8) | c_WORD_W'(w_seg);
    assign w_word_out = (r_word << 8) | c_WORD_W'(SEG_BLANK);

    seg7_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_accept),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_word     <= '0;
            r_dig_cnt  <= '0;
            r_hold_cnt <= '0;
            r_out_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data     <= data_in;
                        r_dig_cnt  <= '0;
                        r_hold_cnt <= '0;
                        r_out_cnt  <= '0;
                        r_state    <= ST_SHIFT_IN;
                    end
                end

                ST_SHIFT_IN: begin
                    if (w_tick) begin
                        r_word <= w_word_in;
                        r_data <= r_data << 4;
                        if (r_dig_cnt == c_DIG_LAST) begin
                            r_dig_cnt <= '0;
                            r_state   <= (HOLD_TICKS == 0) ? ST_SHIFT_OUT : ST_HOLD;
                        end else begin
                            r_dig_cnt <= r_dig_cnt + c_DIG_W'(1);
                        end
                    end
                end

                ST_HOLD: begin
                    if (w_tick) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_hold_cnt <= '0;
                            r_state    <= ST_SHIFT_OUT;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                        end
                    end
                end

                ST_SHIFT_OUT: begin
                    if (w_tick) begin
                        r_word <= w_word_out;
                        if (r_out_cnt == c_OUT_LAST) begin
                            r_out_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_out_cnt <= r_out_cnt + c_OUT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_feed.sv
`default_nettype none
// ============================================================================
// Module : tb_hex_scroll_feed
// Brief  : Self-checking bench for hex_scroll_feed with SEG_UNITS=4,
//          DATA_NIBBLES=8, TICK_DIV=4, HOLD_TICKS=2. A vector table drives
//          complete scroll transactions; hand-written sequences cover
//          valid-while-busy, asynchronous reset mid-scroll and back-to-back
//          acceptance with valid held high.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hex_scroll_feed;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] word;
    logic        busy;

    int checks;
    int passes;
    int fails;

    typedef struct {
        logic [31:0] data;
        logic [31:0] exp4;   // word 4 cycles after acceptance
        logic [31:0] exp16;  // after four digits
        logic [31:0] exp32;  // after all eight digits
    } vec_t;

    vec_t vecs [2];

    hex_scroll_feed #(
        .SEG_UNITS    (4),
        .DATA_NIBBLES (8),
        .TICK_DIV     (24'd4),
        .HOLD_TICKS   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .word       (word),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a value for one edge; on return the accepting edge is "k".
    task automatic accept(input logic [31:0] d);
        data_in    = d;
        data_valid = 1'b1;
        step(1);
        data_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;

        vecs[0] = '{data: 32'h1234ABCD, exp4: 32'h00000006,
                    exp16: 32'h065B4F66, exp32: 32'h777C395E};
        vecs[1] = '{data: 32'h56789EF0, exp4: 32'h0000006D,
                    exp16: 32'h6D7D077F, exp32: 32'h6F79713F};

        // Reset state
        rst_n      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        #2;
        chk("reset_word",  word,              32'h0);
        chk("reset_ready", {31'b0, data_ready}, 32'h1);
        chk("reset_busy",  {31'b0, busy},       32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("idle_word",  word,              32'h0);
        chk("idle_ready", {31'b0, data_ready}, 32'h1);

        // Table-driven full transactions
        for (int i = 0; i < 2; i++) begin
            accept(vecs[i].data);
            step(3);   // k+3
            chk("pre_tick_word", word,                32'h0);
            chk("pre_tick_busy", {31'b0, busy},       32'h1);
            chk("pre_tick_rdy",  {31'b0, data_ready}, 32'h0);
            step(1);   // k+4
            chk("first_digit", word, vecs[i].exp4);
            step(12);  // k+16
            chk("four_digits", word, vecs[i].exp16);
            step(16);  // k+32
            chk("all_digits", word, vecs[i].exp32);
            step(8);   // k+40
            chk("hold_end", word, vecs[i].exp32);
            step(4);   // k+44
            chk("out_first", word, vecs[i].exp32 << 8);
            step(11);  // k+55
            chk("out_third",    word,          vecs[i].exp32 << 24);
            chk("out_busy_end", {31'b0, busy}, 32'h1);
            step(1);   // k+56
            chk("done_word",  word,                32'h0);
            chk("done_ready", {31'b0, data_ready}, 32'h1);
            chk("done_busy",  {31'b0, busy},       32'h0);
            step(3);
        end

        // Valid while busy is ignored, then asynchronous reset mid-scroll
        accept(32'h1234ABCD);
        step(10);  // k+10
        data_in    = 32'hFFFFFFFF;
        data_valid = 1'b1;
        step(2);   // k+12
        data_valid = 1'b0;
        chk("busy_ignore_busy", {31'b0, busy}, 32'h1);
        step(4);   // k+16
        chk("busy_ignore_16", word, 32'h065B4F66);
        step(4);   // k+20
        chk("busy_ignore_20", word, 32'h5B4F6677);
        #3;
        rst_n = 1'b0;
        #1;        // still before the next rising edge
        chk("async_rst_word",  word,                32'h0);
        chk("async_rst_ready", {31'b0, data_ready}, 32'h1);
        chk("async_rst_busy",  {31'b0, busy},       32'h0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_word", word, 32'h0);

        // Clean scroll after reset, then valid held high across completion
        accept(32'h80000000);
        step(4);   // k+4
        chk("new_first", word, 32'h0000007F);
        step(4);   // k+8
        chk("new_second", word, 32'h00007F3F);
        data_in    = 32'h00000000;
        data_valid = 1'b1;
        step(48);  // k+56
        chk("b2b_ready", {31'b0, data_ready}, 32'h1);
        chk("b2b_word0", word,                32'h0);
        step(1);   // k+57: accepted on first idle cycle
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        data_valid = 1'b0;
        step(3);   // k+60
        chk("b2b_pre", word, 32'h0);
        step(1);   // k+61
        chk("b2b_zero_digit", word, 32'h0000003F);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
